// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared op encodings, FSM state type and abs helper for muldiv_unit
package muldiv_pkg;

    localparam logic [3:0] OP_MULT  = 4'b1100;
    localparam logic [3:0] OP_MULTU = 4'b1101;
    localparam logic [3:0] OP_DIV   = 4'b1110;
    localparam logic [3:0] OP_DIVU  = 4'b1111;

    // Working width of abs_val. Callers sign-extend into it and truncate the
    // result back to their own width, so one helper serves any N below this.
    localparam int ABS_W = 256;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FIXUP = 2'd2
    } state_t;

    // Two's-complement magnitude. The most-negative N-bit value sign-extended
    // into ABS_W bits yields 2^(N-1), which truncates to the correct unsigned
    // N-bit magnitude.
    function automatic logic [ABS_W-1:0] abs_val(input logic [ABS_W-1:0] v);
        return v[ABS_W-1] ? (~v + ABS_W'(1)) : v;
    endfunction

endpackage

// File: rtl/muldiv_div_step.sv
// rtl/muldiv_div_step.sv - one restoring-divide iteration (combinational)
//
// Ports:
//   rem_in   partial remainder before this step
//   next_bit next dividend bit shifted into the remainder
//   divisor  divisor magnitude
//   q_bit    quotient bit produced by this step
//   rem_out  partial remainder after this step
module muldiv_div_step #(
    parameter int N = 32
) (
    input  logic [N-1:0] rem_in,
    input  logic         next_bit,
    input  logic [N-1:0] divisor,
    output logic         q_bit,
    output logic [N-1:0] rem_out
);

    // Shifted remainder needs N+1 bits: it can exceed the N-bit range before
    // the trial subtraction brings it back below the divisor.
    logic [N:0] shifted;

    assign shifted = {rem_in, next_bit};
    assign q_bit   = (shifted >= {1'b0, divisor});
    assign rem_out = q_bit ? N'(shifted - {1'b0, divisor}) : shifted[N-1:0];

endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multi-cycle multiply/divide unit owning HI/LO
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   start, op       launch request and operation code (sampled in IDLE only)
//   SrcA, SrcB      multiplicand/dividend, multiplier/divisor
//   abort           cancel an in-flight operation, or a coincident start
//   WriteHi/WriteLo mthi/mtlo strobes with data WD (IDLE only)
//   busy            operation in flight
//   done            one-cycle pulse, coincident with the HI/LO update
//   Hi, Lo          architectural HI/LO registers
//
// Build option: MULDIV_FAST_MUL_EN selects a single-cycle combinational
// multiplier for mult/multu (IDLE -> FIXUP); divide stays iterative.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [3:0]   op,
    input  logic [N-1:0] SrcA,
    input  logic [N-1:0] SrcB,
    input  logic         abort,
    input  logic         WriteHi,
    input  logic         WriteLo,
    input  logic [N-1:0] WD,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] Hi,
    output logic [N-1:0] Lo
);

    localparam int CW = $clog2(N) + 1;

    state_t         state, state_nxt;
    logic [CW-1:0]  cnt;
    // Multiply: {high, low/multiplier}. Divide: {remainder, quotient/dividend}.
    logic [2*N-1:0] acc;
    logic [N-1:0]   opnd;       // multiplicand or divisor magnitude
    logic [N-1:0]   srca_raw;   // dividend as supplied, for divide-by-zero
    logic           is_div;
    logic           neg_res;    // product / quotient must be negated
    logic           neg_rem;    // remainder takes the dividend's sign
    logic           div_zero;

    logic           valid_op, op_is_div, signed_op;
    logic           start_ok, wr_ok;
    logic [N-1:0]   a_mag, b_mag;

    assign valid_op  = (op == OP_MULT) || (op == OP_MULTU) ||
                       (op == OP_DIV)  || (op == OP_DIVU);
    assign op_is_div = (op == OP_DIV)  || (op == OP_DIVU);
    assign signed_op = (op == OP_MULT) || (op == OP_DIV);

    // abort wins over a coincident start; start wins over the HI/LO strobes.
    assign start_ok = (state == S_IDLE) && start && valid_op && !abort;
    assign wr_ok    = (state == S_IDLE) && !start_ok;

    assign a_mag = signed_op ? N'(abs_val(ABS_W'($signed(SrcA)))) : SrcA;
    assign b_mag = signed_op ? N'(abs_val(ABS_W'($signed(SrcB)))) : SrcB;

    assign busy = (state != S_IDLE);

    // Shift-add multiply step: conditionally add the multiplicand into the
    // high half, then shift the whole accumulator right one place.
    logic [N:0] mul_sum;
    assign mul_sum = {1'b0, acc[2*N-1:N]} + (acc[0] ? {1'b0, opnd} : (N+1)'(0));

    logic         div_q_bit;
    logic [N-1:0] div_rem;

    muldiv_div_step #(.N(N)) u_div_step (
        .rem_in   (acc[2*N-1:N]),
        .next_bit (acc[N-1]),
        .divisor  (opnd),
        .q_bit    (div_q_bit),
        .rem_out  (div_rem)
    );

`ifdef MULDIV_FAST_MUL_EN
    logic [2*N-1:0] fast_prod;
    assign fast_prod = (2*N)'(a_mag) * (2*N)'(b_mag);
`endif

    // Sign fix-ups applied on the FIXUP cycle.
    logic [2*N-1:0] prod_fix;
    logic [N-1:0]   quo_fix, rem_fix;
    assign prod_fix = neg_res ? -acc : acc;
    assign quo_fix  = neg_res ? -acc[N-1:0] : acc[N-1:0];
    assign rem_fix  = neg_rem ? -acc[2*N-1:N] : acc[2*N-1:N];

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_ok) begin
`ifdef MULDIV_FAST_MUL_EN
                    state_nxt = op_is_div ? S_RUN : S_FIXUP;
`else
                    state_nxt = S_RUN;
`endif
                end
            end
            S_RUN: begin
                if (abort)
                    state_nxt = S_IDLE;
                else if (cnt == '0)
                    state_nxt = S_FIXUP;
            end
            S_FIXUP:  state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            opnd     <= '0;
            srca_raw <= '0;
            is_div   <= 1'b0;
            neg_res  <= 1'b0;
            neg_rem  <= 1'b0;
            div_zero <= 1'b0;
            done     <= 1'b0;
            Hi       <= '0;
            Lo       <= '0;
        end else begin
            state <= state_nxt;
            done  <= 1'b0;

            if (wr_ok) begin
                if (WriteHi) Hi <= WD;
                if (WriteLo) Lo <= WD;
            end

            case (state)
                S_IDLE: begin
                    if (start_ok) begin
                        cnt      <= CW'(N - 1);
                        is_div   <= op_is_div;
                        neg_res  <= signed_op & (SrcA[N-1] ^ SrcB[N-1]);
                        neg_rem  <= signed_op & SrcA[N-1];
                        div_zero <= (SrcB == '0);
                        srca_raw <= SrcA;
                        if (op_is_div) begin
                            acc  <= {(N)'(0), a_mag};
                            opnd <= b_mag;
                        end else begin
`ifdef MULDIV_FAST_MUL_EN
                            acc  <= fast_prod;
`else
                            acc  <= {(N)'(0), b_mag};
`endif
                            opnd <= a_mag;
                        end
                    end
                end
                S_RUN: begin
                    if (!abort) begin
                        if (cnt != '0)
                            cnt <= cnt - CW'(1);
                        if (is_div)
                            acc <= {div_rem, acc[N-2:0], div_q_bit};
                        else
                            acc <= {mul_sum, acc[N-1:1]};
                    end
                end
                S_FIXUP: begin
                    if (!abort) begin
                        done <= 1'b1;
                        if (!is_div) begin
                            Hi <= prod_fix[2*N-1:N];
                            Lo <= prod_fix[N-1:0];
                        end else if (div_zero) begin
                            Hi <= srca_raw;
                            Lo <= '1;
                        end else begin
                            Hi <= rem_fix;
                            Lo <= quo_fix;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
